// File: rtl/sdpram32_stream_reader.sv
// Read-side client for the 32-bit simple dual-port RAM. It fetches a contiguous
// run of words over a 2-cycle-latency read port and emits them as a valid/ready stream.
module sdpram32_stream_reader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  ram_read_addr,
  output logic                   ram_read_enable,
  input  logic [31:0]            ram_read_data,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = PTR_W + 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   done_q, done_d;
  logic                   issue, issue_last;

  // In-flight tags: stage 1 = read issued last cycle, stage 2 = data on the bus now.
  logic s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;

  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic             fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push, pop;
  logic [CRD_W-1:0] credit_used;
  logic             have_credit;

  assign push = s2_valid_q;
  assign pop  = out_valid & out_ready;

  // Credits count buffered words after this cycle's pop plus every read still in flight.
  assign credit_used = CRD_W'(count_q) - CRD_W'(pop) + CRD_W'(s1_valid_q) + CRD_W'(s2_valid_q);
  assign have_credit = credit_used < CRD_W'(FIFO_DEPTH);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d      = base_addr;
            remaining_d = word_count;
            state_d     = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (have_credit) begin
          issue       = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - COUNT_WIDTH'(1);
          if (remaining_q == COUNT_WIDTH'(1)) begin
            issue_last = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      s1_valid_q  <= issue;
      s1_last_q   <= issue_last;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // NOTE: the storage array is not reset; the occupancy count alone decides which
  // entries are meaningful, and out_data is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= ram_read_data;
      fifo_last[wr_ptr_q] <= s2_last_q;
    end
  end

  assign out_valid       = (count_q != '0);
  assign out_data        = out_valid ? fifo_data[rd_ptr_q] : '0;
  assign out_last        = out_valid & fifo_last[rd_ptr_q];
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign ram_read_enable = issue;
  assign ram_read_addr   = addr_q;

endmodule
